srio_pkt_segmenter: RTL and testbench

- Parametrised successor to the SRIO input reader. Takes one user transfer of up to 2^LEN_WIDTH bytes and splits it into SRIO NWRITE payload packets of at most 2^MAX_PKT_LOG2 bytes.
- Zero-pads the tail packet up to a legal size and buffers the result in a FIFO with full backpressure on both sides.
- Feeds the NWR request builder. Each output beat carries its packet length, packet index and transfer-done marker.
- Added over the previous generation:
  - generic data width and max payload;
  - selectable tail rounding;
  - input backpressure during padding;
  - length-mismatch handling.

---
 rtl/srio_pkt_segmenter.sv | 260 ++++++++++++++++++++++++++
 tb/tb_srio_pkt_segmenter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/srio_pkt_segmenter.sv
// SRIO NWRITE payload segmenter: cuts one user transfer into max-size packets,
// pads the tail packet and buffers tagged beats in a first-word-fall-through FIFO.
module srio_pkt_segmenter #(
    parameter int DATA_WIDTH      = 64,
    parameter int LEN_WIDTH       = 16,
    parameter int MAX_PKT_LOG2    = 8,
    parameter int MIN_PKT_BYTES   = 16,
    parameter int ROUND_POW2      = 1,
    parameter int FIFO_ADDR_WIDTH = 7
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH-1:0]             s_data,
    input  logic                              s_valid,
    input  logic                              s_first,
    input  logic [DATA_WIDTH/8-1:0]           s_keep,
    input  logic [LEN_WIDTH-1:0]              s_len,
    input  logic                              s_last,
    output logic                              s_ready,
    output logic [DATA_WIDTH-1:0]             m_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [DATA_WIDTH/8-1:0]           m_keep,
    output logic                              m_first,
    output logic                              m_last,
    output logic [MAX_PKT_LOG2-1:0]           m_len,
    output logic [LEN_WIDTH-MAX_PKT_LOG2-1:0] m_pkt_idx,
    output logic                              m_done,
    output logic                              ack,
    output logic                              err_len
);

    localparam int B         = DATA_WIDTH / 8;
    localparam int BL        = $clog2(B);
    localparam int PL        = MAX_PKT_LOG2 - BL;
    localparam int IW        = LEN_WIDTH - MAX_PKT_LOG2;
    localparam int AW        = FIFO_ADDR_WIDTH;
    localparam int EW        = DATA_WIDTH + B + 3 + MAX_PKT_LOG2 + IW;
    localparam int MIN_BEATS = (MIN_PKT_BYTES / B < 1) ? 1 : MIN_PKT_BYTES / B;
    localparam logic [PL:0]   MIN_T    = MIN_BEATS[PL:0];
    localparam logic [PL:0]   T_ONE    = {{PL{1'b0}}, 1'b1};
    localparam logic [PL-1:0] BEAT_ONE = {{(PL-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DATA = 2'd1, ST_PAD = 2'd2, ST_DRAIN = 2'd3} state_t;

    // Tail beats rounded up to a power of two no smaller than the minimum packet.
    function automatic logic [PL:0] round_tail(input logic [PL:0] t);
        logic [PL:0] r;
        r = MIN_T;
        for (int i = 0; i <= PL; i++) begin
            r = (r < t) ? (r << 1) : r;
        end
        return (ROUND_POW2 != 0) ? r : t;
    endfunction

    state_t                  state_r;
    logic [IW-1:0]           last_idx_r, idx_r;
    logic [PL:0]             tail_t_r, tail_r_r;
    logic [MAX_PKT_LOG2-1:0] tail_len_r;
    logic [PL-1:0]           beat_r;
    logic                    err_len_r;

    logic [IW-1:0]           new_last_idx_s, cur_last_idx_s, cur_idx_s, nxt_idx_s;
    logic [PL:0]             new_t_s, new_r_s, cur_t_s, cur_r_s;
    logic [MAX_PKT_LOG2-1:0] new_tail_len_s, cur_tail_len_s, cur_len_s;
    logic [PL-1:0]           cur_beat_s, nxt_beat_s;
    logic                    is_tail_s, pkt_end_s, done_s, data_end_s, data_err_s;
    state_t                  data_next_s;
    logic                    s_ready_s, wr_en_s, pad_s, full_s, empty_s, load_s;
    logic [EW-1:0]           entry_s;
    logic                    unused_len_bits_s;

    logic [EW-1:0]           mem_r [2**AW];
    logic [AW:0]             wr_ptr_r, rd_ptr_r;
    logic [DATA_WIDTH-1:0]   m_data_r;
    logic [B-1:0]            m_keep_r;
    logic                    m_valid_r, m_first_r, m_last_r, m_done_r;
    logic [MAX_PKT_LOG2-1:0] m_len_r;
    logic [IW-1:0]           m_idx_r;

    assign unused_len_bits_s = ^s_len[BL-1:0];

    // Length arithmetic for a transfer starting on this beat.
    always_comb begin
        new_last_idx_s = s_len[LEN_WIDTH-1:MAX_PKT_LOG2];
        new_t_s        = {1'b0, s_len[MAX_PKT_LOG2-1:BL]} + T_ONE;
        new_r_s        = round_tail(new_t_s);
        new_tail_len_s = MAX_PKT_LOG2'({new_r_s, {BL{1'b0}}} - {{MAX_PKT_LOG2{1'b0}}, 1'b1});
    end

    // Position of the current beat; in IDLE the incoming s_first beat is beat 0.
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_last_idx_s = new_last_idx_s;
            cur_t_s        = new_t_s;
            cur_r_s        = new_r_s;
            cur_tail_len_s = new_tail_len_s;
            cur_idx_s      = {IW{1'b0}};
            cur_beat_s     = {PL{1'b0}};
        end else begin
            cur_last_idx_s = last_idx_r;
            cur_t_s        = tail_t_r;
            cur_r_s        = tail_r_r;
            cur_tail_len_s = tail_len_r;
            cur_idx_s      = idx_r;
            cur_beat_s     = beat_r;
        end
        is_tail_s  = (cur_idx_s == cur_last_idx_s);
        done_s     = is_tail_s && ({1'b0, cur_beat_s} == cur_r_s - T_ONE);
        data_end_s = is_tail_s && ({1'b0, cur_beat_s} == cur_t_s - T_ONE);
        pkt_end_s  = is_tail_s ? done_s : (&cur_beat_s);
        cur_len_s  = is_tail_s ? cur_tail_len_s : {MAX_PKT_LOG2{1'b1}};
        nxt_beat_s = pkt_end_s ? {PL{1'b0}} : cur_beat_s + BEAT_ONE;
        nxt_idx_s  = pkt_end_s ? cur_idx_s + IDX_ONE : cur_idx_s;
        if (data_end_s) begin
            data_err_s  = !s_last;
            data_next_s = !s_last ? ST_DRAIN : ((cur_r_s > cur_t_s) ? ST_PAD : ST_IDLE);
        end else if (s_last) begin
            data_err_s  = 1'b1;
            data_next_s = ST_PAD;
        end else begin
            data_err_s  = 1'b0;
            data_next_s = ST_DATA;
        end
    end

    // Input handshake and FIFO write entry.
    always_comb begin
        s_ready_s = 1'b0;
        wr_en_s   = 1'b0;
        pad_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                s_ready_s = ~full_s;
                wr_en_s   = s_valid && s_first && !full_s;
            end
            ST_DATA: begin
                s_ready_s = ~full_s;
                wr_en_s   = s_valid && !s_first && !full_s;
            end
            ST_PAD: begin
                wr_en_s = !full_s;
                pad_s   = 1'b1;
            end
            ST_DRAIN: s_ready_s = 1'b1;
            default:  s_ready_s = 1'b0;
        endcase
        entry_s = {pad_s ? {DATA_WIDTH{1'b0}} : s_data, pad_s ? {B{1'b0}} : s_keep,
                   (cur_beat_s == {PL{1'b0}}), pkt_end_s, done_s, cur_len_s, cur_idx_s};
    end

    // Segmentation state machine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            last_idx_r <= {IW{1'b0}};
            idx_r      <= {IW{1'b0}};
            tail_t_r   <= {(PL+1){1'b0}};
            tail_r_r   <= {(PL+1){1'b0}};
            tail_len_r <= {MAX_PKT_LOG2{1'b0}};
            beat_r     <= {PL{1'b0}};
            err_len_r  <= 1'b0;
        end else begin
            err_len_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (wr_en_s) begin
                        last_idx_r <= new_last_idx_s;
                        tail_t_r   <= new_t_s;
                        tail_r_r   <= new_r_s;
                        tail_len_r <= new_tail_len_s;
                        beat_r     <= nxt_beat_s;
                        idx_r      <= nxt_idx_s;
                        err_len_r  <= data_err_s;
                        state_r    <= data_next_s;
                    end
                end
                ST_DATA: begin
                    if (s_valid && s_first && !full_s) begin
                        err_len_r <= 1'b1;
                    end else if (wr_en_s) begin
                        beat_r    <= nxt_beat_s;
                        idx_r     <= nxt_idx_s;
                        err_len_r <= data_err_s;
                        state_r   <= data_next_s;
                    end
                end
                ST_PAD: begin
                    if (wr_en_s) begin
                        beat_r <= nxt_beat_s;
                        idx_r  <= nxt_idx_s;
                        if (done_s) state_r <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (s_valid && s_first) begin
                        err_len_r <= 1'b1;
                    end else if (s_valid && s_last) begin
                        state_r <= (tail_r_r > tail_t_r) ? ST_PAD : ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign load_s  = !empty_s && (!m_valid_r || m_ready);

    // FIFO storage; contents are meaningless until the pointers cover them.
    always_ff @(posedge clk) begin
        if (wr_en_s) mem_r[wr_ptr_r[AW-1:0]] <= entry_s;
    end

    // FIFO pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (load_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

    // Output register: holds a beat until the downstream takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid_r <= 1'b0;
            m_data_r  <= {DATA_WIDTH{1'b0}};
            m_keep_r  <= {B{1'b0}};
            m_first_r <= 1'b0;
            m_last_r  <= 1'b0;
            m_done_r  <= 1'b0;
            m_len_r   <= {MAX_PKT_LOG2{1'b0}};
            m_idx_r   <= {IW{1'b0}};
        end else if (load_s) begin
            {m_data_r, m_keep_r, m_first_r, m_last_r, m_done_r, m_len_r, m_idx_r} <= mem_r[rd_ptr_r[AW-1:0]];
            m_valid_r <= 1'b1;
        end else if (m_ready) begin
            m_valid_r <= 1'b0;
        end
    end

    assign s_ready   = s_ready_s;
    assign m_data    = m_data_r;
    assign m_valid   = m_valid_r;
    assign m_keep    = m_keep_r;
    assign m_first   = m_first_r;
    assign m_last    = m_last_r;
    assign m_len     = m_len_r;
    assign m_pkt_idx = m_idx_r;
    assign m_done    = m_done_r;
    assign ack       = m_valid_r && m_ready && m_done_r;
    assign err_len   = err_len_r;

endmodule

// File: tb/tb_srio_pkt_segmenter.sv
// Directed bench for srio_pkt_segmenter: instance 0 default, 1 exact tails, 2 small FIFO.
module tb_srio_pkt_segmenter;

    localparam int NI = 3;
    localparam int BW = 91;

    typedef struct {
        int          inst;
        logic [15:0] len;
        int          nbeats;
        int          last_at;
        int          total;
        int          pkts;
        logic [7:0]  tail_len;
        int          dbeats;
        int          errs;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] s_data = 64'h0;
    logic        s_valid = 1'b0, s_first = 1'b0, s_last = 1'b0, m_ready = 1'b1;
    logic [7:0]  s_keep = 8'h0;
    logic [15:0] s_len = 16'h0;

    logic        s_ready_a [NI];
    logic [63:0] m_data_a  [NI];
    logic        m_valid_a [NI];
    logic [7:0]  m_keep_a  [NI];
    logic        m_first_a [NI];
    logic        m_last_a  [NI];
    logic [7:0]  m_len_a   [NI];
    logic [7:0]  m_idx_a   [NI];
    logic        m_done_a  [NI];
    logic        ack_a     [NI];
    logic        err_a     [NI];

    int sel = 0;
    int ncmp = 0, nfail = 0;
    int ack_cnt = 0, err_cnt = 0, acc_cnt = 0;
    logic tog = 1'b0;
    logic [BW-1:0] obs_q[$];
    vec_t vecs[9];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        srio_pkt_segmenter #(
            .ROUND_POW2((g == 1) ? 0 : 1),
            .FIFO_ADDR_WIDTH((g == 2) ? 4 : 7)
        ) dut (
            .clk(clk), .reset(reset),
            .s_data(s_data), .s_valid(s_valid), .s_first(s_first), .s_keep(s_keep),
            .s_len(s_len), .s_last(s_last), .s_ready(s_ready_a[g]),
            .m_data(m_data_a[g]), .m_valid(m_valid_a[g]), .m_ready(m_ready),
            .m_keep(m_keep_a[g]), .m_first(m_first_a[g]), .m_last(m_last_a[g]),
            .m_len(m_len_a[g]), .m_pkt_idx(m_idx_a[g]), .m_done(m_done_a[g]),
            .ack(ack_a[g]), .err_len(err_a[g])
        );
    end

    // Output monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (m_valid_a[sel] && m_ready)
                obs_q.push_back({m_data_a[sel], m_keep_a[sel], m_first_a[sel], m_last_a[sel],
                                 m_done_a[sel], m_len_a[sel], m_idx_a[sel]});
            if (ack_a[sel]) ack_cnt++;
            if (err_a[sel]) err_cnt++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (tog) m_ready = ~m_ready;
        end
    end

    task automatic chk(input string name, input int idx, input logic [95:0] act, input logic [95:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; tog = 1'b0; m_ready = 1'b1;
        s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        obs_q.delete();
        ack_cnt = 0; err_cnt = 0; acc_cnt = 0;
    endtask

    task automatic send(input logic [31:0] tag, input logic [15:0] len, input int nb, input int last_at);
        for (int i = 0; i < nb; i++) begin
            int w;
            @(negedge clk);
            s_valid = 1'b1; s_first = (i == 0); s_last = (i == last_at);
            s_data = {tag, 32'(i)}; s_keep = ~8'(i); s_len = len;
            w = 0;
            while (!s_ready_a[sel] && w < 2000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 2000) begin
                ncmp++; nfail++;
                $display("FAIL send_stall[%0d]: s_ready stuck at 0, expected 1 within 2000 cycles", i);
                s_valid = 1'b0;
                return;
            end
            @(posedge clk);
            acc_cnt++;
        end
        @(negedge clk);
        s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
    endtask

    task automatic check_out(input vec_t v, input logic [31:0] tag);
        int w;
        w = 0;
        while (obs_q.size() < v.total && w < 3000) begin
            @(negedge clk);
            w++;
        end
        repeat (8) @(negedge clk);
        chk("beat_count", v.inst, obs_q.size(), v.total);
        for (int j = 0; j < v.total; j++) begin
            int pkt, pos, pb;
            logic tail;
            logic [BW-1:0] e;
            pkt  = j / 32;
            pos  = j % 32;
            tail = (pkt == v.pkts - 1);
            pb   = tail ? v.total - 32 * (v.pkts - 1) : 32;
            e = {(j < v.dbeats) ? {tag, 32'(j)} : 64'h0, (j < v.dbeats) ? ~8'(j) : 8'h00,
                 (pos == 0), (pos == pb - 1), (j == v.total - 1),
                 tail ? v.tail_len : 8'hFF, 8'(pkt)};
            if (j < obs_q.size()) chk("beat", j, obs_q[j], e);
        end
        chk("ack_count", v.inst, ack_cnt, 1);
        chk("err_count", v.inst, err_cnt, v.errs);
    endtask

    initial begin
        vec_t bp, rs;
        vecs[0] = '{0, 16'h00FF, 32, 31, 32, 1, 8'hFF, 32, 0};
        vecs[1] = '{0, 16'h0104, 33, 32, 34, 2, 8'h0F, 33, 0};
        vecs[2] = '{0, 16'h0027,  5,  4,  8, 1, 8'h3F,  5, 0};
        vecs[3] = '{1, 16'h0027,  5,  4,  5, 1, 8'h27,  5, 0};
        vecs[4] = '{0, 16'h003F,  3,  2,  8, 1, 8'h3F,  3, 1};
        vecs[5] = '{0, 16'h003F, 10,  9,  8, 1, 8'h3F,  8, 1};
        vecs[6] = '{1, 16'h0104, 33, 32, 33, 2, 8'h07, 33, 0};
        vecs[7] = '{0, 16'h0007,  1,  0,  2, 1, 8'h0F,  1, 0};
        vecs[8] = '{1, 16'h0000,  1,  0,  1, 1, 8'h07,  1, 0};
        bp      = '{2, 16'h01FF, 64, 63, 64, 2, 8'hFF, 64, 0};
        rs      = '{0, 16'h000F,  2,  1,  2, 1, 8'h0F,  2, 0};

        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 0, {m_valid_a[0], ack_a[0], err_a[0], m_first_a[0], m_last_a[0], m_done_a[0],
                                 m_len_a[0], m_idx_a[0], m_keep_a[0], m_data_a[0]}, 96'h0);
        chk("reset_s_ready", 0, s_ready_a[0], 1);

        for (int k = 0; k < 9; k++) begin
            do_reset();
            sel = vecs[k].inst;
            send(32'hC0DE_0000 + k, vecs[k].len, vecs[k].nbeats, vecs[k].last_at);
            check_out(vecs[k], 32'hC0DE_0000 + k);
        end

        // Backpressure: 16 FIFO entries plus the output register fill before s_ready drops.
        do_reset();
        sel = 2;
        m_ready = 1'b0;
        fork
            send(32'hB0B0_0001, bp.len, bp.nbeats, bp.last_at);
            begin
                int w;
                w = 0;
                @(negedge clk);
                #1;
                while (s_ready_a[2] && w < 500) begin
                    @(negedge clk);
                    #1;
                    w++;
                end
                chk("bp_accepted", 2, acc_cnt, 17);
                tog = 1'b1;
            end
        join
        check_out(bp, 32'hB0B0_0001);

        // Reset in the middle of a transfer, then a fresh transfer right after release.
        do_reset();
        sel = 0;
        send(32'hAAAA_0000, 16'h00FF, 12, -1);
        @(negedge clk);
        s_valid = 1'b1; s_first = 1'b0; s_data = 64'h1234; s_keep = 8'hFF;
        chk("pre_reset_valid", 0, m_valid_a[0], 1);
        reset = 1'b1;
        #1;
        chk("mid_reset_valid", 0, m_valid_a[0], 0);
        chk("mid_reset_ready", 0, s_ready_a[0], 1);
        @(negedge clk);
        reset = 1'b0; s_valid = 1'b0;
        obs_q.delete();
        ack_cnt = 0; err_cnt = 0; acc_cnt = 0;
        #1;
        chk("post_reset_ready", 0, s_ready_a[0], 1);
        send(32'hAAAA_0001, rs.len, rs.nbeats, rs.last_at);
        check_out(rs, 32'hAAAA_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
